conv_window_feeder: RTL and testbench

//  Producer side of the convolution multiply-adder input bus. Accepts a raster-order

---
 rtl/conv_window_feeder_pkg.sv | 10 +
 rtl/conv_line_buffer.sv | 23 ++
 rtl/conv_window_feeder.sv | 93 +++++++++
 tb/tb_conv_window_feeder.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_window_feeder_pkg.sv
// conv_window_feeder_pkg: network-level sizes and feeder state type
package conv_window_feeder_pkg;
    localparam int KERNEL_SIZE     = 3;
    localparam int CONV_MULT_WIDTH = 8;
    localparam int KERNEL_SIZE_SQ  = KERNEL_SIZE * KERNEL_SIZE;
    localparam int IMAGE_WIDTH     = 28;
    localparam int IMAGE_HEIGHT    = 28;
    localparam int WINDOW_BITWIDTH = KERNEL_SIZE_SQ * CONV_MULT_WIDTH - 1;
    typedef enum logic {FILL, STREAM} feeder_state_e;
endpackage

// File: rtl/conv_line_buffer.sv
// conv_line_buffer: DEPTH-entry row delay; q_o is the sample written DEPTH writes ago
module conv_line_buffer #(
    parameter int W     = 8,
    parameter int DEPTH = 28
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         we_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] ptr_q, ptr_d;
    assign q_o   = mem[ptr_q];
    assign ptr_d = (ptr_q == AW'(DEPTH - 1)) ? '0 : ptr_q + AW'(1);
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) ptr_q <= '0;
        else if (we_i) ptr_q <= ptr_d;
    // storage is deliberately left uncleared; stale rows are gated out by the FSM
    always_ff @(posedge clk_i)
        if (we_i) mem[ptr_q] <= d_i;
endmodule

// File: rtl/conv_window_feeder.sv
// conv_window_feeder: raster pixel stream to packed K x K valid-padding windows
module conv_window_feeder
    import conv_window_feeder_pkg::*;
#(
    parameter int K  = KERNEL_SIZE,
    parameter int W  = CONV_MULT_WIDTH,
    parameter int IW = IMAGE_WIDTH,
    parameter int IH = IMAGE_HEIGHT
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [W-1:0]     pixel_i,
    input  logic             pixel_valid_i,
    output logic             pixel_ready_o,
    output logic [K*K*W-1:0] window_o,
    output logic             window_valid_o,
    input  logic             window_ready_i,
    output logic             frame_done_o
);
    localparam int CW       = IW > 1 ? $clog2(IW) : 1;
    localparam int RW       = IH > 1 ? $clog2(IH) : 1;
    localparam int FILL_ROW = K > 1 ? K - 2 : 0;
    localparam feeder_state_e RST_STATE = K > 1 ? FILL : STREAM;
    feeder_state_e    state_q, state_d;
    logic [CW-1:0]    col_q, col_d;
    logic [RW-1:0]    row_q, row_d;
    logic [K*K*W-1:0] sr_q, nw, win_q, win_d;
    logic             wv_q, wv_d, fd_q, fd_d;
    logic             accept, emit, load, col_last, row_last;
    logic [W-1:0]     tap [K];
    assign pixel_ready_o  = !wv_q || window_ready_i;
    assign accept         = pixel_valid_i && pixel_ready_o;
    assign emit           = wv_q && window_ready_i;
    assign col_last       = col_q == CW'(IW - 1);
    assign row_last       = row_q == RW'(IH - 1);
    assign load           = accept && state_q == STREAM && col_q >= CW'(K - 1);
    assign window_o       = win_q;
    assign window_valid_o = wv_q;
    assign frame_done_o   = fd_q;
    // tap[j] is the pixel j rows above the incoming one, same column
    assign tap[0] = pixel_i;
    for (genvar j = 1; j < K; j++) begin : g_lb
        conv_line_buffer #(.W(W), .DEPTH(IW)) u_lb (
            .clk_i(clk_i),
            .rst_i(rst_i),
            .we_i (accept),
            .d_i  (tap[j-1]),
            .q_o  (tap[j])
        );
    end
    // element a*K+b shifts left one column; the rightmost column takes the taps
    for (genvar a = 0; a < K; a++) begin : g_row
        for (genvar b = 0; b < K; b++) begin : g_col
            if (b == K - 1) begin : g_new
                assign nw[W*(a*K+b) +: W] = tap[K-1-a];
            end else begin : g_old
                assign nw[W*(a*K+b) +: W] = sr_q[W*(a*K+b+1) +: W];
            end
        end
    end
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        if (accept) begin
            col_d = col_last ? '0 : col_q + CW'(1);
            row_d = col_last ? (row_last ? '0 : row_q + RW'(1)) : row_q;
            if (col_last && state_q == FILL && row_q == RW'(FILL_ROW)) state_d = STREAM;
            if (col_last && row_last) state_d = RST_STATE;
        end
        wv_d  = load || (wv_q && !emit);
        win_d = load ? nw : win_q;
        fd_d  = accept && col_last && row_last;
    end
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            state_q <= RST_STATE;
            col_q   <= '0;
            row_q   <= '0;
            sr_q    <= '0;
            win_q   <= '0;
            wv_q    <= 1'b0;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            if (accept) sr_q <= nw;
            win_q   <= win_d;
            wv_q    <= wv_d;
            fd_q    <= fd_d;
        end
endmodule

// File: tb/tb_conv_window_feeder.sv
// tb_conv_window_feeder: directed table, stall/reset sequences and a queue-based window model
module tb_conv_window_feeder;
    localparam int K = 3, W = 8, IW = 4, IH = 4, WB = K*K*W;
    typedef struct {
        logic [7:0]    pix;
        logic          ewv;
        logic          efd;
        logic [WB-1:0] ewin;
    } vec_t;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst = 1'b1, pv = 1'b0, wr = 1'b0, pr, wv, fd;
    logic [7:0] pix = '0;
    logic [WB-1:0] win;
    logic pv2 = 1'b0, wr2 = 1'b0, pr2, wv2, fd2;
    logic [7:0] pix2 = '0;
    logic [WB-1:0] win2;
    int vecs = 0, errs = 0;
    int nwin = 0, nfd = 0, k2 = 0, nfd2 = 0;
    bit rand_wr = 0, rand_wr2 = 0;
    conv_window_feeder #(.K(K), .W(W), .IW(IW), .IH(IH)) dut (
        .clk_i(clk), .rst_i(rst), .pixel_i(pix), .pixel_valid_i(pv), .pixel_ready_o(pr),
        .window_o(win), .window_valid_o(wv), .window_ready_i(wr), .frame_done_o(fd)
    );
    conv_window_feeder dut2 (
        .clk_i(clk), .rst_i(rst), .pixel_i(pix2), .pixel_valid_i(pv2), .pixel_ready_o(pr2),
        .window_o(win2), .window_valid_o(wv2), .window_ready_i(wr2), .frame_done_o(fd2)
    );
    task automatic chk(input string nm, input logic [WB-1:0] act, input logic [WB-1:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask
    // reference: record accepted pixels in an image array, queue each completed window
    logic [7:0]    img [IH][IW];
    logic [WB-1:0] q [$];
    int mr = 0, mc = 0;
    logic fd_pend = 1'b0, rdy;
    function automatic logic [WB-1:0] mk(input int r, input int c);
        logic [WB-1:0] v;
        for (int a = 0; a < K; a++)
            for (int b = 0; b < K; b++)
                v[W*(a*K+b) +: W] = img[r-K+1+a][c-K+1+b];
        return v;
    endfunction
    function automatic logic [WB-1:0] ramp4(input int r, input int c, input int base);
        logic [WB-1:0] v;
        for (int a = 0; a < K; a++)
            for (int b = 0; b < K; b++)
                v[W*(a*K+b) +: W] = 8'((r-K+1+a)*IW + (c-K+1+b) + base);
        return v;
    endfunction
    function automatic logic [WB-1:0] ramp28(input int k);
        logic [WB-1:0] v;
        int r, c;
        r = 2 + k / 26;
        c = 2 + k % 26;
        for (int a = 0; a < K; a++)
            for (int b = 0; b < K; b++)
                v[W*(a*K+b) +: W] = 8'((r-2+a)*28 + (c-2+b));
        return v;
    endfunction
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            mr = 0;
            mc = 0;
            fd_pend = 1'b0;
            chk("rst_wv", wv, 0);
            chk("rst_fd", fd, 0);
            chk("rst_pr", pr, 1);
            chk("rst_win", win, 0);
        end else begin
            chk("wv", wv, q.size() != 0);
            chk("fd", fd, fd_pend);
            rdy = q.size() == 0 || wr;
            chk("pr", pr, rdy);
            if (q.size() != 0) chk("win", win, q[0]);
            if (fd) nfd++;
            fd_pend = 1'b0;
            if (q.size() != 0 && wr) begin
                void'(q.pop_front());
                nwin++;
            end
            if (pv && rdy) begin
                img[mr][mc] = pix;
                if (mr >= K-1 && mc >= K-1) q.push_back(mk(mr, mc));
                fd_pend = mr == IH-1 && mc == IW-1;
                mc++;
                if (mc == IW) begin
                    mc = 0;
                    mr = (mr + 1) % IH;
                end
            end
        end
        if (!rst && wv2 && wr2) begin
            chk("big_win", win2, ramp28(k2));
            k2++;
        end
        if (!rst && fd2) nfd2++;
    end
    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_wr) wr = $urandom_range(3) != 0;
        if (rand_wr2) wr2 = $urandom_range(3) != 0;
    endtask
    task automatic send(input logic [7:0] p);
        logic acc;
        acc = 1'b0;
        pix = p;
        pv = 1'b1;
        for (int n = 0; n < 200 && !acc; n++) begin
            #1 acc = pr;
            tick();
        end
        pv = 1'b0;
        if (!acc) begin
            vecs++;
            errs++;
            $display("FAIL send_timeout: pixel %0d not accepted within 200 cycles", p);
        end
    endtask
    task automatic frame(input int base, input int gap_pct);
        for (int i = 0; i < IW*IH; i++) begin
            if ($urandom_range(99) < gap_pct) tick();
            send(8'(base + i));
        end
    endtask
    task automatic drain();
        rand_wr = 0;
        wr = 1'b1;
        repeat (4) tick();
    endtask
    task automatic do_reset();
        rst = 1'b1;
        pv = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask
    vec_t tab [IW*IH];
    int n0, f0;
    initial begin
        for (int r = 0; r < IH; r++)
            for (int c = 0; c < IW; c++) begin
                tab[r*IW+c].pix  = 8'(r*IW + c + 1);
                tab[r*IW+c].ewv  = r >= K-1 && c >= K-1;
                tab[r*IW+c].efd  = r == IH-1 && c == IW-1;
                tab[r*IW+c].ewin = tab[r*IW+c].ewv ? ramp4(r, c, 1) : '0;
            end
        tick();
        tick();
        rst = 1'b0;
        wr = 1'b1;
        #1;
        chk("reset_wv", wv, 0);
        chk("reset_win", win, 0);
        chk("reset_pr", pr, 1);
        chk("reset_fd", fd, 0);
        for (int i = 0; i < IW*IH; i++) begin
            pix = tab[i].pix;
            pv = 1'b1;
            tick();
            chk("tab_wv", wv, tab[i].ewv);
            chk("tab_fd", fd, tab[i].efd);
            if (tab[i].ewv) chk("tab_win", win, tab[i].ewin);
        end
        pv = 1'b0;
        tick();
        chk("tab_fd_clear", fd, 0);
        do_reset();
        wr = 1'b0;
        for (int i = 1; i <= 11; i++) send(8'(i));
        pix = 8'd12;
        pv = 1'b1;
        repeat (5) begin
            #1;
            chk("stall_pr", pr, 0);
            chk("stall_wv", wv, 1);
            chk("stall_win", win, ramp4(2, 2, 1));
            tick();
        end
        pv = 1'b0;
        wr = 1'b1;
        send(8'd12);
        chk("release_win", win, ramp4(2, 3, 1));
        for (int i = 13; i <= 16; i++) send(8'(i));
        drain();
        do_reset();
        n0 = nwin;
        frame(1, 50);
        drain();
        chk("gap_windows", 72'(nwin - n0), 4);
        do_reset();
        n0 = nwin;
        f0 = nfd;
        frame(1, 0);
        frame(101, 0);
        drain();
        chk("b2b_windows", 72'(nwin - n0), 8);
        chk("b2b_frame_done", 72'(nfd - f0), 2);
        for (int i = 1; i <= 9; i++) send(8'(i));
        rst = 1'b1;
        tick();
        #1;
        chk("midrst_wv", wv, 0);
        tick();
        rst = 1'b0;
        n0 = nwin;
        frame(1, 0);
        drain();
        chk("midrst_windows", 72'(nwin - n0), 4);
        n0 = nwin;
        rand_wr = 1;
        for (int f = 0; f < 3; f++) frame(int'($urandom_range(200)), 30);
        drain();
        chk("rand_windows", 72'(nwin - n0), 12);
        wr2 = 1'b1;
        rand_wr2 = 1;
        for (int i = 0; i < 28*28; i++) begin
            logic acc;
            acc = 1'b0;
            if ($urandom_range(3) == 0) tick();
            pix2 = 8'(i);
            pv2 = 1'b1;
            for (int n = 0; n < 200 && !acc; n++) begin
                #1 acc = pr2;
                tick();
            end
            pv2 = 1'b0;
            if (!acc) begin
                vecs++;
                errs++;
                $display("FAIL big_send_timeout: pixel %0d not accepted", i);
            end
        end
        rand_wr2 = 0;
        wr2 = 1'b1;
        repeat (4) tick();
        chk("big_windows", 72'(k2), 676);
        chk("big_frame_done", 72'(nfd2), 1);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
